// File: rtl/ascon_permutation_iter.sv
// ---------------------------------------------------------------------------
// ascon_permutation_iter
//
// Iterative ASCON permutation engine. A registered 320-bit state is advanced
// by one full round (constant addition, substitution layer, linear diffusion
// layer) per clock. p^a runs rounds (12-NB_ROUNDS_A)..11, and p^b runs rounds
// (12-NB_ROUNDS_B)..11.
//
// State packing: {x0, x1, x2, x3, x4}. x0 occupies bits [319:256] and x4
// occupies bits [63:0].
//
// Ports:
//   clock_i   in   1    system clock, rising edge
//   resetb_i  in   1    asynchronous reset, active-low
//   start_i   in   1    start request (accepted in IDLE or DONE)
//   mode_i    in   1    0 = p^a, 1 = p^b (sampled with start_i)
//   state_i   in   320  input state, loaded on an accepted start
//   state_o   out  320  state register
//   round_o   out  4    round index fed to the constant-addition stage
//   busy_o    out  1    high while rounds are being applied
//   done_o    out  1    one-cycle pulse; state_o holds the result
//
// Optional build macro: ASCON_DOUBLE_ROUND_EN
//   When defined, two round datapaths are chained, so each RUN edge applies
//   rounds r and r+1. The counter steps by 2 and round_o shows the first
//   index of each pair. Both round-count parameters must then be even.
// ---------------------------------------------------------------------------
module ascon_permutation_iter #(
  parameter int NB_ROUNDS_A = 12,
  parameter int NB_ROUNDS_B = 6
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic [3:0]   round_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_e;

  localparam logic [3:0] START_A = 4'(12 - NB_ROUNDS_A);
  localparam logic [3:0] START_B = 4'(12 - NB_ROUNDS_B);

`ifdef ASCON_DOUBLE_ROUND_EN
  localparam logic [3:0] STEP      = 4'd2;
  // The final pair is (10, 11), so the last RUN edge sees the counter at 10.
  localparam logic [3:0] LAST_IDX  = 4'd10;
`else
  localparam logic [3:0] STEP      = 4'd1;
  localparam logic [3:0] LAST_IDX  = 4'd11;
`endif

  // Elaboration-time parameter sanity checks
  if ((NB_ROUNDS_A < 1) || (NB_ROUNDS_A > 12)) begin : g_bad_a
    $error("NB_ROUNDS_A must be in 1..12");
  end
  if ((NB_ROUNDS_B < 1) || (NB_ROUNDS_B > 12)) begin : g_bad_b
    $error("NB_ROUNDS_B must be in 1..12");
  end
`ifdef ASCON_DOUBLE_ROUND_EN
  if ((NB_ROUNDS_A % 2) != 0) begin : g_odd_a
    $error("NB_ROUNDS_A must be even with ASCON_DOUBLE_ROUND_EN");
  end
  if ((NB_ROUNDS_B % 2) != 0) begin : g_odd_b
    $error("NB_ROUNDS_B must be even with ASCON_DOUBLE_ROUND_EN");
  end
`endif

  // 64-bit rotate right
  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (32'd64 - n));
  endfunction

  // One full ASCON round on a packed state
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    // Constant addition: round constant is {~r, r} in nibbles.
    x2[7:0] = x2[7:0] ^ {4'hF - r, r};
    // Bit-sliced 5-bit S-box across all 64 columns
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    // Linear diffusion layer
    x0 = x0 ^ rotr(x0, 32'd19) ^ rotr(x0, 32'd28);
    x1 = x1 ^ rotr(x1, 32'd61) ^ rotr(x1, 32'd39);
    x2 = x2 ^ rotr(x2, 32'd1)  ^ rotr(x2, 32'd6);
    x3 = x3 ^ rotr(x3, 32'd10) ^ rotr(x3, 32'd17);
    x4 = x4 ^ rotr(x4, 32'd7)  ^ rotr(x4, 32'd41);
    return {x0, x1, x2, x3, x4};
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [319:0] st_q, st_d;
  logic [3:0]   round_q, round_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [319:0] rnd_s;

  // Round datapath: one round, or two chained rounds in the double build
`ifdef ASCON_DOUBLE_ROUND_EN
  logic [319:0] rnd_first_s;
  always_comb begin
    rnd_first_s = ascon_round(st_q, round_q);
    rnd_s       = ascon_round(rnd_first_s, round_q + 4'd1);
  end
`else
  always_comb begin
    rnd_s = ascon_round(st_q, round_q);
  end
`endif

  // Next-state logic for FSM, state register, round counter and flags
  always_comb begin
    fsm_d   = fsm_q;
    st_d    = st_q;
    round_d = round_q;
    case (fsm_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          st_d    = state_i;
          round_d = mode_i ? START_B : START_A;
          fsm_d   = S_RUN;
        end else begin
          fsm_d   = S_IDLE;
        end
      end
      S_RUN: begin
        st_d = rnd_s;
        if (round_q == LAST_IDX) begin
          // Counter saturates here; it never wraps past the last round.
          fsm_d = S_DONE;
        end else begin
          round_d = round_q + STEP;
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
    busy_d = (fsm_d == S_RUN);
    done_d = (fsm_d == S_DONE);
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= S_IDLE;
      st_q    <= 320'd0;
      round_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      st_q    <= st_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign state_o = st_q;
  assign round_o = round_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_ascon_permutation_iter.sv
module tb_ascon_permutation_iter;

  localparam int NB_A = 12;
  localparam int NB_B = 6;
`ifdef ASCON_DOUBLE_ROUND_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  // ASCON S-box as a lookup table; x0 is the MSB of the 5-bit column value.
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  logic         clk = 1'b0;
  logic         resetb = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [319:0] state_in = 320'd0;
  logic [319:0] state_out;
  logic [3:0]   round_out;
  logic         busy_out;
  logic         done_out;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  ascon_permutation_iter #(.NB_ROUNDS_A(NB_A), .NB_ROUNDS_B(NB_B)) dut (
    .clock_i (clk),
    .resetb_i(resetb),
    .start_i (start),
    .mode_i  (mode),
    .state_i (state_in),
    .state_o (state_out),
    .round_o (round_out),
    .busy_o  (busy_out),
    .done_o  (done_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_rc(input int r);
    return 8'(((15 - r) * 16) + r);
  endfunction

  function automatic logic [319:0] m_sbox_layer(input logic [319:0] s);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  v;
    logic [4:0]  o;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    for (int c = 0; c < 64; c++) begin
      for (int i = 0; i < 5; i++) v[4 - i] = x[i][c];
      o = SBOX[v];
      for (int i = 0; i < 5; i++) y[i][c] = o[4 - i];
    end
    return {y[0], y[1], y[2], y[3], y[4]};
  endfunction

  function automatic logic [319:0] m_linear(input logic [319:0] s);
    logic [63:0]  w;
    logic [127:0] d;
    logic [319:0] r;
    for (int i = 0; i < 5; i++) begin
      w = s[319 - 64*i -: 64];
      d = {w, w};
      r[319 - 64*i -: 64] = w ^ 64'(d >> ROT_A[i]) ^ 64'(d >> ROT_B[i]);
    end
    return r;
  endfunction

  function automatic logic [319:0] m_round(input logic [319:0] s, input int r);
    logic [319:0] t;
    t = s;
    t[135:128] = t[135:128] ^ m_rc(r);
    return m_linear(m_sbox_layer(t));
  endfunction

  typedef struct {
    logic [319:0] st;
    logic [3:0]   rnd;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t exp_q [$];
  exp_t cur;

  // Expected per-cycle outputs for a permutation accepted at this edge
  task automatic build_traj(input logic [319:0] s_in, input logic m);
    int n, first, edges;
    logic [319:0] s;
    exp_t e;
    n = m ? NB_B : NB_A;
    first = 12 - n;
    edges = n / STEP;
    s = s_in;
    exp_q.delete();
    e.st = s; e.rnd = 4'(first); e.busy = 1'b1; e.done = 1'b0;
    exp_q.push_back(e);
    for (int k = 1; k <= edges; k++) begin
      for (int j = 0; j < STEP; j++) s = m_round(s, first + STEP*(k-1) + j);
      e.st = s;
      if (k < edges) begin
        e.rnd = 4'(first + STEP*k); e.busy = 1'b1; e.done = 1'b0;
      end else begin
        e.rnd = 4'(first + STEP*(edges-1)); e.busy = 1'b0; e.done = 1'b1;
      end
      exp_q.push_back(e);
    end
  endtask

  // Model update and output compare, once per cycle
  initial begin
    cur.st = 320'd0; cur.rnd = 4'd0; cur.busy = 1'b0; cur.done = 1'b0;
    forever begin
      @(posedge clk);
      if (!resetb) begin
        exp_q.delete();
        cur.st = 320'd0; cur.rnd = 4'd0; cur.busy = 1'b0; cur.done = 1'b0;
      end else if (start && !cur.busy) begin
        build_traj(state_in, mode);
        cur = exp_q.pop_front();
      end else if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
      end else begin
        cur.busy = 1'b0;
        cur.done = 1'b0;
      end
      #1;
      chk("state_o", state_out, cur.st);
      chk("round_o", 320'(round_out), 320'(cur.rnd));
      chk("busy_o", 320'(busy_out), 320'(cur.busy));
      chk("done_o", 320'(done_out), 320'(cur.done));
      if (done_out) done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [319:0] rand_state();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic m, input logic [319:0] s);
    start = 1'b1; mode = m; state_in = s;
    tick(1);
    start = 1'b0; state_in = rand_state();
  endtask

  initial begin
    int d0;
    logic [319:0] lin_in;
    logic [319:0] lin_exp;
    logic [319:0] sb_exp;

    // Reset state held across a few edges
    tick(3);
    chk("reset_state", state_out, 320'd0);
    resetb = 1'b1;
    tick(2);

    // Pin the model with hand-computed values
    chk("rc0", 320'(m_rc(0)), 320'(8'hf0));
    chk("rc11", 320'(m_rc(11)), 320'(8'h4b));
    sb_exp = {64'd0, 64'd0, 64'hffffffffffffffff, 64'd0, 64'd0};
    chk("sbox_zero", m_sbox_layer(320'd0), sb_exp);
    lin_in  = {64'd1, 256'd0};
    lin_exp = {64'h0000_2010_0000_0001, 256'd0};
    chk("linear_x0", m_linear(lin_in), lin_exp);

    // p^a on the reference vector
    d0 = done_cnt;
    pulse_start(1'b0, {64'h80400c0600000000, 256'd0});
    tick(16);
    chk("pa_done_count", 320'(done_cnt - d0), 320'd1);

    // p^b on the all-zero state
    d0 = done_cnt;
    pulse_start(1'b1, 320'd0);
    tick(10);
    chk("pb_done_count", 320'(done_cnt - d0), 320'd1);

    // Start during RUN is ignored
    d0 = done_cnt;
    pulse_start(1'b0, rand_state());
    tick(2);
    start = 1'b1; mode = 1'b1; state_in = rand_state();
    tick(1);
    start = 1'b0;
    tick(16);
    chk("ignored_start_done_count", 320'(done_cnt - d0), 320'd1);

    // Back-to-back, start held high, fresh state every cycle
    start = 1'b1; mode = 1'b0;
    for (int i = 0; i < 40; i++) begin state_in = rand_state(); tick(1); end
    mode = 1'b1;
    for (int i = 0; i < 30; i++) begin state_in = rand_state(); tick(1); end
    start = 1'b0;
    tick(16);

    // Randomised traffic
    for (int i = 0; i < 200; i++) begin
      start = ($urandom_range(0, 3) == 0);
      mode = 1'($urandom_range(0, 1));
      state_in = rand_state();
      tick(1);
    end
    start = 1'b0;
    tick(16);

    // Asynchronous reset in the middle of a p^a
    pulse_start(1'b0, rand_state());
    tick(4);
    #2 resetb = 1'b0;
    #1;
    chk("async_rst_state", state_out, 320'd0);
    chk("async_rst_round", 320'(round_out), 320'd0);
    chk("async_rst_busy", 320'(busy_out), 320'd0);
    chk("async_rst_done", 320'(done_out), 320'd0);
    tick(2);
    resetb = 1'b1;
    d0 = done_cnt;
    tick(16);
    chk("no_done_after_reset", 320'(done_cnt - d0), 320'd0);

    // One more p^a after the abort
    d0 = done_cnt;
    pulse_start(1'b0, {64'h80400c0600000000, 256'd0});
    tick(16);
    chk("pa_after_reset_done_count", 320'(done_cnt - d0), 320'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascon_permutation_iter.md
Name: ascon_permutation_iter

Overview:
- Iterative ASCON permutation engine: one full round (constant addition, then substitution layer, then linear diffusion layer) per clock on a registered 320-bit state.
- Owns the round counter that drives the constant-addition stage's `round_i`. It is the sequential stage directly upstream of that stage, and it also consumes that stage's output.
- Runs p^a (12 rounds, indices 0..11) or p^b (6 rounds, indices 6..11) on request.
- Used by the ascon128 top-level FSM for initialization, absorb, squeeze and finalization.

Parameters:
- `NB_ROUNDS_A`, default 12: round count for p^a. The start index is 12 - `NB_ROUNDS_A`.
- `NB_ROUNDS_B`, default 6: round count for p^b. The start index is 12 - `NB_ROUNDS_B`.

Ports:
- `clock_i`  in  1  system clock, rising edge.
- `resetb_i`  in  1  asynchronous reset, active-low.
- `start_i`  in  1  request to start a permutation; sampled on the rising edge.
- `mode_i`  in  1  0 = p^a, 1 = p^b; sampled together with `start_i`.
- `state_i`  in  `type_state` (5x64)  input state, loaded on an accepted start.
- `state_o`  out  `type_state` (5x64)  registered state, always equal to the state register.
- `round_o`  out  4  current round index; this is the value presented to the constant-addition stage.
- `busy_o`  out  1  high while rounds are being applied.
- `done_o`  out  1  one-cycle pulse; `state_o` holds the final result in that cycle.

Behaviour:
- Reset: asynchronous, active-low, on `resetb_i`. All registers clear immediately, independent of `clock_i`:
  - state register = 0
  - `round_o` = 0
  - FSM = IDLE
  - `busy_o` = 0
  - `done_o` = 0
- FSM states are IDLE, RUN and DONE. All outputs are registered.
- IDLE:
  - If `start_i` = 1: load state register <= `state_i`; round counter <= (`mode_i` ? 12 - `NB_ROUNDS_B` : 12 - `NB_ROUNDS_A`); go to RUN.
  - Otherwise hold.
- RUN, on each edge:
  - state register <= round(state register, round counter).
  - If round counter = 11: go to DONE; round counter holds at 11.
  - Otherwise: round counter +1.
  - `busy_o` = 1 throughout RUN.
- DONE:
  - `done_o` = 1 and `busy_o` = 0 for exactly this one cycle.
  - `state_o` = result, and it is held stable afterwards until the next accepted start.
  - A `start_i` seen in DONE is accepted exactly as in IDLE (back-to-back permutations). Otherwise go to IDLE.
- Latency, with start sampled at edge E0:
  - p^a: rounds applied at E1..E12; `done_o` high between E12 and E13.
  - p^b: rounds applied at E1..E6; `done_o` high between E6 and E7.
- `start_i` during RUN is ignored. It is not queued, and `mode_i` and `state_i` are not re-sampled.
- Round constant: the round counter is never outside 0..11. It never wraps; it saturates at 11 when the last round completes.
- Round datapath is combinational and purely word-wise on `type_state`:
  - Constant addition XORs `round_constant[round]` into `x2[7:0]`.
  - Substitution layer: 5-bit S-box, bit-sliced across the 64 columns.
  - Diffusion layer uses rotation pairs (19,28), (61,39), (1,6), (10,17), (7,41) for x0..x4.
- Reset mid-operation aborts the permutation: FSM returns to IDLE, no `done_o` pulse, state register cleared.

Optional Feature:
- Macro: `ASCON_DOUBLE_ROUND_EN`.
- Defined:
  - Two round datapaths are chained; each RUN edge applies rounds r and r+1.
  - Round counter steps by 2; completion is detected when r+1 = 11.
  - p^a takes 6 RUN edges and p^b takes 3; `done_o` comes at E6+1 and E3+1 respectively.
  - `round_o` shows the first index of the pair.
  - Both `NB_ROUNDS` parameters must be even; an elaboration-time check rejects odd values.
- Undefined: single round per edge, exactly as described in Behaviour.

Test Plan:
- Reset check: assert `resetb_i` = 0 mid-RUN of a p^a.
  - `state_o` = 0, `busy_o` = 0, `done_o` = 0 and `round_o` = 0 immediately, without waiting for a clock edge.
  - No `done_o` pulse after release.
- p^a run: load `state_i` = {x0=80400c0600000000, x1..x4=0}, `mode_i` = 0.
  - `round_o` sequence is 0,1,...,11.
  - `done_o` is asserted only in the cycle after E12, and `state_o` equals the golden model's p^a output.
- p^b run: all-zero state, `mode_i` = 1.
  - `round_o` sequence is 6..11.
  - `done_o` is asserted after E6, and `state_o` equals the golden model's p^b(0) output.
- Ignored start: assert `start_i` = 1 with a different `state_i` at E3 of a p^a run.
  - The result is unchanged versus an undisturbed run.
  - Still exactly one `done_o` pulse.
- Back-to-back: `start_i` held high continuously.
  - A new permutation starts in the DONE cycle.
  - `done_o` pulses every 13 cycles for p^a and every 7 cycles for p^b.
  - The second result equals the permutation applied to that start's `state_i`.
- With `ASCON_DOUBLE_ROUND_EN`: repeat the p^a and p^b vectors.
  - Results are identical to the single-round build.
  - `done_o` comes after E6 (p^a) and E3 (p^b).
  - `round_o` sequence is 0,2,...,10 for p^a and 6,8,10 for p^b.
